// File: rtl/call_stack.sv
// call_stack: return-address stack for the control unit.
//   Holds DEPTH = 2**DEPTH_LOG2 program addresses and presents the current
//   top entry with no read latency. CALL pushes a return address, RET pops;
//   a simultaneous push and pop replaces the top entry in place.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   push       store push_addr as new top this cycle
//   pop        remove current top this cycle
//   push_addr  return address to store (AW bits)
//   top        current top entry, zero when empty
//   sp         entry count 0..DEPTH (DEPTH_LOG2+1 bits)
//   empty      sp == 0
//   full       sp == DEPTH
//   overflow   one-cycle pulse: push rejected because full
//   underflow  one-cycle pulse: pop rejected because empty
// Optional feature (macro CALL_STACK_STICKY_ERR_EN):
//   err_clr    clears err_sticky when sampled high on an edge
//   err_sticky latched flag set by any overflow/underflow event
module call_stack #(
  parameter int AW         = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [AW-1:0]         push_addr,
  output logic [AW-1:0]         top,
  output logic [DEPTH_LOG2:0]   sp,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
`ifdef CALL_STACK_STICKY_ERR_EN
  ,
  input  logic                  err_clr,
  output logic                  err_sticky
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE       = (DEPTH_LOG2 + 1)'(1);

  logic [AW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2:0]   sp_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;

  logic [DEPTH_LOG2:0]   sp_m1;
  logic [DEPTH_LOG2-1:0] top_idx;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic                  replace;
  logic                  do_push;
  logic                  do_pop;
  logic                  wr_en;
  logic                  ov_evt;
  logic                  un_evt;

  assign sp_m1   = sp_reg - ONE;
  assign top_idx = sp_m1[DEPTH_LOG2-1:0];

  assign empty = (sp_reg == '0);
  assign full  = (sp_reg == DEPTH_CNT);
  assign sp    = sp_reg;
  assign top   = empty ? '0 : mem[top_idx];

  // push&pop on a non-empty stack overwrites the top entry (even when full).
  // push&pop on an empty stack falls through to an ordinary push.
  assign replace = push & pop & ~empty;
  assign do_push = push & ~replace & ~full;
  assign do_pop  = pop & ~push & ~empty;
  assign ov_evt  = push & ~pop & full;
  assign un_evt  = pop & ~push & empty;

  assign wr_en  = replace | do_push;
  assign wr_idx = replace ? top_idx : sp_reg[DEPTH_LOG2-1:0];

  // Entry storage is deliberately never cleared; sp alone defines validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= push_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_reg        <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      overflow_reg  <= ov_evt;
      underflow_reg <= un_evt;
      if (do_push) begin
        sp_reg <= sp_reg + ONE;
      end else if (do_pop) begin
        sp_reg <= sp_m1;
      end
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

`ifdef CALL_STACK_STICKY_ERR_EN
  logic sticky_reg;

  // A new error on the same edge as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_reg <= 1'b0;
    end else if (ov_evt | un_evt) begin
      sticky_reg <= 1'b1;
    end else if (err_clr) begin
      sticky_reg <= 1'b0;
    end
  end

  assign err_sticky = sticky_reg;
`endif

endmodule

// File: tb/tb_call_stack.sv
module tb_call_stack;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] push_addr = '0;
  logic [7:0] top;
  logic [3:0] sp;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       underflow;
  logic       clr = 1'b0;
`ifdef CALL_STACK_STICKY_ERR_EN
  logic       err_sticky;
`endif

  always #5 clk = ~clk;

  call_stack #(.AW(8), .DEPTH_LOG2(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_addr (push_addr),
    .top       (top),
    .sp        (sp),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef CALL_STACK_STICKY_ERR_EN
    ,
    .err_clr   (clr),
    .err_sticky(err_sticky)
`endif
  );

  typedef struct {
    string      name;
    logic [3:0] sp;
    logic [7:0] top;
    logic       ov;
    logic       un;
    logic       st;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string n, input string what, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s.%s: got %0h, expected %0h", n, what, act, expv);
  endtask

  // Monitor: compares DUT outputs mid-cycle against queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        $display("vec %-12s sp=%0d top=%02h empty=%0b full=%0b ov=%0b un=%0b",
                 e.name, sp, top, empty, full, overflow, underflow);
        chk(e.name, "sp",        int'(sp),        int'(e.sp));
        chk(e.name, "top",       int'(top),       int'(e.top));
        chk(e.name, "empty",     int'(empty),     int'(e.sp == 4'd0));
        chk(e.name, "full",      int'(full),      int'(e.sp == 4'd8));
        chk(e.name, "overflow",  int'(overflow),  int'(e.ov));
        chk(e.name, "underflow", int'(underflow), int'(e.un));
`ifdef CALL_STACK_STICKY_ERR_EN
        chk(e.name, "sticky",    int'(err_sticky), int'(e.st));
`endif
      end
    end
  end

  // Called at posedge+1: drive one request, let the edge happen, queue the
  // state expected after that edge.
  task automatic vec(input string n, input bit p, input bit q, input logic [7:0] a,
                     input bit c, input logic [3:0] esp, input logic [7:0] etop,
                     input bit eov, input bit eun, input bit est);
    exp_t e;
    push = p; pop = q; push_addr = a; clr = c;
    @(posedge clk);
    #1;
    e.name = n; e.sp = esp; e.top = etop; e.ov = eov; e.un = eun; e.st = est;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1. reset then idle
    vec("rst_idle0", 0, 0, 8'h00, 0, 4'd0, 8'h00, 0, 0, 0);
    vec("rst_idle1", 0, 0, 8'h00, 0, 4'd0, 8'h00, 0, 0, 0);
    // 2. push three, pop three
    vec("push10", 1, 0, 8'h10, 0, 4'd1, 8'h10, 0, 0, 0);
    vec("push20", 1, 0, 8'h20, 0, 4'd2, 8'h20, 0, 0, 0);
    vec("push30", 1, 0, 8'h30, 0, 4'd3, 8'h30, 0, 0, 0);
    vec("pop_a",  0, 1, 8'h00, 0, 4'd2, 8'h20, 0, 0, 0);
    vec("pop_b",  0, 1, 8'h00, 0, 4'd1, 8'h10, 0, 0, 0);
    vec("pop_c",  0, 1, 8'h00, 0, 4'd0, 8'h00, 0, 0, 0);
    // 4. underflow and sticky flag
    vec("underflow", 0, 1, 8'h00, 0, 4'd0, 8'h00, 0, 1, 1);
    vec("un_clear",  0, 0, 8'h00, 0, 4'd0, 8'h00, 0, 0, 1);
    vec("err_clr",   0, 0, 8'h00, 1, 4'd0, 8'h00, 0, 0, 0);
    vec("un_setwin", 0, 1, 8'h00, 1, 4'd0, 8'h00, 0, 1, 1);
    vec("err_clr2",  0, 0, 8'h00, 1, 4'd0, 8'h00, 0, 0, 0);
    // 3. fill, then overflow
    for (int i = 0; i < 8; i++) begin
      vec($sformatf("fill%0d", i), 1, 0, 8'hA0 + 8'(i), 0,
          4'(i + 1), 8'hA0 + 8'(i), 0, 0, 0);
    end
    vec("overflow",  1, 0, 8'hFF, 0, 4'd8, 8'hA7, 1, 0, 1);
    vec("overflow2", 1, 0, 8'hFE, 0, 4'd8, 8'hA7, 1, 0, 1);
    vec("ov_clear",  0, 0, 8'h00, 1, 4'd8, 8'hA7, 0, 0, 0);
    // 5. replace at full, then replace at sp=2, then on empty
    vec("repl_full", 1, 1, 8'h66, 0, 4'd8, 8'h66, 0, 0, 0);
    vec("pop7", 0, 1, 8'h00, 0, 4'd7, 8'hA6, 0, 0, 0);
    vec("pop6", 0, 1, 8'h00, 0, 4'd6, 8'hA5, 0, 0, 0);
    vec("pop5", 0, 1, 8'h00, 0, 4'd5, 8'hA4, 0, 0, 0);
    vec("pop4", 0, 1, 8'h00, 0, 4'd4, 8'hA3, 0, 0, 0);
    vec("pop3", 0, 1, 8'h00, 0, 4'd3, 8'hA2, 0, 0, 0);
    vec("pop2", 0, 1, 8'h00, 0, 4'd2, 8'hA1, 0, 0, 0);
    vec("repl_sp2",  1, 1, 8'h55, 0, 4'd2, 8'h55, 0, 0, 0);
    vec("pop_r1",    0, 1, 8'h00, 0, 4'd1, 8'hA0, 0, 0, 0);
    vec("pop_r0",    0, 1, 8'h00, 0, 4'd0, 8'h00, 0, 0, 0);
    vec("repl_empty", 1, 1, 8'h77, 0, 4'd1, 8'h77, 0, 0, 0);
    vec("pop_e",     0, 1, 8'h00, 0, 4'd0, 8'h00, 0, 0, 0);
    // 6. async reset mid-stream at sp=5
    for (int i = 0; i < 5; i++) begin
      vec($sformatf("pre_rst%0d", i), 1, 0, 8'h01 + 8'(i), 0,
          4'(i + 1), 8'h01 + 8'(i), 0, 0, 0);
    end
    push = 0; pop = 0; clr = 0;
    @(negedge clk);            // previous expectation compared here
    #1;
    rst = 1'b1;                // between edges, no clock edge while asserted
    e.name = "async_rst"; e.sp = 4'd0; e.top = 8'h00; e.ov = 0; e.un = 0; e.st = 0;
    sb.push_back(e);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    vec("post_rst", 1, 0, 8'hC3, 0, 4'd1, 8'hC3, 0, 0, 0);
    push = 0; pop = 0; clr = 0;

    for (int k = 0; k < 6 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
